// File: rtl/ex_result_collect.sv
// rtl/ex_result_collect.sv - EX-stage result selector with multi-cycle unit stall/wait and timeout
module ex_result_collect #(
  parameter int                   DATA_WIDTH = 32,
  parameter int                   NUM_UNITS  = 4,
  parameter int                   TAG_WIDTH  = 5,
  parameter logic [NUM_UNITS-1:0] MULTI_MASK = 4'b0110,
  parameter int                   TIMEOUT    = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            issue_valid,
  input  logic [NUM_UNITS-1:0]            issue_sel,
  input  logic [TAG_WIDTH-1:0]            issue_tag,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_result,
  input  logic [NUM_UNITS-1:0]            unit_done,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [TAG_WIDTH-1:0]            out_tag,
  output logic                            stall_req,
  output logic                            sel_error
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [NUM_UNITS-1:0]  cap_sel_q;
  logic [TAG_WIDTH-1:0]  cap_tag_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [TAG_WIDTH-1:0]  out_tag_q;
  logic                  sel_error_q;

  logic issue_onehot;
  logic issue_multi;
  logic done_hit;

  // AND-OR mux over the packed unit results; select is known one-hot here
  function automatic logic [DATA_WIDTH-1:0] pick(input logic [NUM_UNITS-1:0]            s,
                                                 input logic [NUM_UNITS*DATA_WIDTH-1:0] r);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (s[k]) v = v | r[k*DATA_WIDTH +: DATA_WIDTH];
    end
    return v;
  endfunction

  assign issue_onehot = (issue_sel != '0) &&
                        ((issue_sel & (issue_sel - NUM_UNITS'(1))) == '0);
  assign issue_multi  = |(issue_sel & MULTI_MASK);
  assign done_hit     = |(unit_done & cap_sel_q);

  // Stall drops in the done cycle so the issue stage can advance alongside the result
  always_comb begin
    stall_req = 1'b0;
    if (state_q == S_IDLE) stall_req = issue_valid && issue_onehot && issue_multi;
    else                   stall_req = !done_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cap_sel_q   <= '0;
      cap_tag_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      sel_error_q <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      sel_error_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      sel_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (issue_valid) begin
            if (!issue_onehot) begin
              out_valid_q <= 1'b1;
              out_data_q  <= '0;
              out_tag_q   <= issue_tag;
              sel_error_q <= 1'b1;
            end else if (issue_multi) begin
              cap_sel_q <= issue_sel;
              cap_tag_q <= issue_tag;
              cnt_q     <= '0;
              state_q   <= S_WAIT;
            end else begin
              out_valid_q <= 1'b1;
              out_data_q  <= pick(issue_sel, unit_result);
              out_tag_q   <= issue_tag;
            end
          end
        end
        S_WAIT: begin
          // Done is tested before the timeout so a done on the final count still completes
          if (done_hit) begin
            out_valid_q <= 1'b1;
            out_data_q  <= pick(cap_sel_q, unit_result);
            out_tag_q   <= cap_tag_q;
            cnt_q       <= '0;
            state_q     <= S_IDLE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            sel_error_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign sel_error = sel_error_q;

endmodule

// File: tb/tb_ex_result_collect.sv
// tb/tb_ex_result_collect.sv - directed table-driven bench for ex_result_collect
module tb_ex_result_collect;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         issue_valid;
  logic [3:0]   issue_sel;
  logic [4:0]   issue_tag;
  logic [127:0] unit_result;
  logic [3:0]   unit_done;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [4:0]   out_tag;
  logic         stall_req;
  logic         sel_error;

  int checks = 0;
  int errors = 0;

  ex_result_collect dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .issue_valid(issue_valid),
    .issue_sel  (issue_sel),
    .issue_tag  (issue_tag),
    .unit_result(unit_result),
    .unit_done  (unit_done),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .stall_req  (stall_req),
    .sel_error  (sel_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   sel;
    logic [4:0]   tag;
    logic [127:0] res;
    logic         exp_stall;
    logic         exp_err;
    logic [31:0]  exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int stall_cnt;
    int err_cnt;
    int valid_cnt;
    int first_err;

    vecs[0] = '{4'b0001, 5'd3,  {32'hA3, 32'hA2, 32'hA1, 32'h5},        1'b0, 1'b0, 32'h5};
    vecs[1] = '{4'b1000, 5'd9,  {32'hFF, 32'hB2, 32'hB1, 32'hB0},       1'b0, 1'b0, 32'hFF};
    vecs[2] = '{4'b0101, 5'd2,  {32'hC3, 32'hC2, 32'hC1, 32'hC0},       1'b0, 1'b1, 32'h0};
    vecs[3] = '{4'b0000, 5'd4,  {32'hD3, 32'hD2, 32'hD1, 32'hD0},       1'b0, 1'b1, 32'h0};
    vecs[4] = '{4'b0110, 5'd6,  {32'hE3, 32'hE2, 32'hE1, 32'hE0},       1'b0, 1'b1, 32'h0};
    vecs[5] = '{4'b0001, 5'd31, {32'h1, 32'h2, 32'h3, 32'hDEADBEEF},    1'b0, 1'b0, 32'hDEADBEEF};

    rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_sel = '0; issue_tag = '0;
    unit_result = '0; unit_done = '0;
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  out_data,       32'd0);
    chk("rst_tag",   32'(out_tag),   32'd0);
    chk("rst_err",   32'(sel_error), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    rst = 1'b0;

    // table: single-cycle and illegal-select issues
    for (int i = 0; i < 6; i++) begin
      issue_valid = 1'b1; issue_sel = vecs[i].sel; issue_tag = vecs[i].tag;
      unit_result = vecs[i].res;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall_req), 32'(vecs[i].exp_stall));
      step();
      issue_valid = 1'b0; unit_result = '0;
      #1;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_data", i),  out_data,       vecs[i].exp_data);
      chk($sformatf("v%0d_tag", i),   32'(out_tag),   32'(vecs[i].tag));
      chk($sformatf("v%0d_err", i),   32'(sel_error), 32'(vecs[i].exp_err));
      step();
      chk($sformatf("v%0d_valid_drop", i), 32'(out_valid), 32'd0);
      chk($sformatf("v%0d_err_drop", i),   32'(sel_error), 32'd0);
      chk($sformatf("v%0d_data_hold", i),  out_data,       vecs[i].exp_data);
    end

    // multi-cycle divider-style wait, done after 4 WAIT cycles
    issue_valid = 1'b1; issue_sel = 4'b0010; issue_tag = 5'd7; unit_done = 4'b0010;
    unit_result = '0; unit_result[32 +: 32] = 32'h111;
    #1;
    stall_cnt = int'(stall_req);
    chk("a_issue_stall", 32'(stall_req), 32'd1);
    step();
    issue_valid = 1'b0; unit_done = '0;
    for (int i = 0; i < 4; i++) begin
      unit_done   = (i == 1) ? 4'b0100 : 4'b0000;
      issue_valid = (i == 2);
      issue_sel   = (i == 2) ? 4'b0001 : 4'b0010;
      #1;
      stall_cnt += int'(stall_req);
      chk($sformatf("a_wait%0d_valid", i), 32'(out_valid), 32'd0);
      step();
    end
    issue_valid = 1'b0; unit_done = 4'b0010; unit_result[32 +: 32] = 32'hC8;
    #1;
    chk("a_done_stall", 32'(stall_req), 32'd0);
    step();
    unit_done = '0; unit_result = '0;
    #1;
    chk("a_valid",     32'(out_valid), 32'd1);
    chk("a_data",      out_data,       32'hC8);
    chk("a_tag",       32'(out_tag),   32'd7);
    chk("a_err",       32'(sel_error), 32'd0);
    chk("a_stall_len", 32'(stall_cnt), 32'd5);
    step();
    chk("a_valid_drop", 32'(out_valid), 32'd0);

    // timeout with no done
    issue_valid = 1'b1; issue_sel = 4'b0100; issue_tag = 5'd10;
    #1;
    stall_cnt = int'(stall_req);
    step();
    issue_valid = 1'b0;
    err_cnt = 0; valid_cnt = 0; first_err = -1;
    for (int i = 0; i < 70; i++) begin
      #1;
      stall_cnt += int'(stall_req);
      if (out_valid) valid_cnt++;
      if (sel_error) begin
        err_cnt++;
        if (first_err < 0) first_err = i;
      end
      step();
    end
    chk("b_err_pulses", 32'(err_cnt),   32'd1);
    chk("b_err_cycle",  32'(first_err), 32'd64);
    chk("b_valid_none", 32'(valid_cnt), 32'd0);
    chk("b_stall_len",  32'(stall_cnt), 32'd65);
    chk("b_stall_low",  32'(stall_req), 32'd0);
    issue_valid = 1'b1; issue_sel = 4'b1000; issue_tag = 5'd12; unit_result[96 +: 32] = 32'h77;
    step();
    issue_valid = 1'b0; unit_result = '0;
    #1;
    chk("b_after_valid", 32'(out_valid), 32'd1);
    chk("b_after_data",  out_data,       32'h77);
    chk("b_after_tag",   32'(out_tag),   32'd12);

    // done coincident with the final count completes without error
    issue_valid = 1'b1; issue_sel = 4'b0100; issue_tag = 5'd3;
    step();
    issue_valid = 1'b0;
    repeat (63) step();
    unit_done = 4'b0100; unit_result[64 +: 32] = 32'hABC;
    #1;
    chk("f_done_stall", 32'(stall_req), 32'd0);
    step();
    unit_done = '0; unit_result = '0;
    #1;
    chk("f_valid", 32'(out_valid), 32'd1);
    chk("f_data",  out_data,       32'hABC);
    chk("f_tag",   32'(out_tag),   32'd3);
    chk("f_err",   32'(sel_error), 32'd0);
    step();
    chk("f_err_after", 32'(sel_error), 32'd0);

    // flush mid-WAIT together with the captured unit's done
    issue_valid = 1'b1; issue_sel = 4'b0100; issue_tag = 5'd1;
    step();
    issue_valid = 1'b0;
    step();
    flush = 1'b1; unit_done = 4'b0100; unit_result[64 +: 32] = 32'h999;
    step();
    flush = 1'b0; unit_done = '0; unit_result = '0;
    #1;
    chk("c_stall", 32'(stall_req), 32'd0);
    chk("c_valid", 32'(out_valid), 32'd0);
    chk("c_err",   32'(sel_error), 32'd0);
    chk("c_data",  out_data,       32'hABC);
    chk("c_tag",   32'(out_tag),   32'd3);
    step();
    chk("c_valid2", 32'(out_valid), 32'd0);
    chk("c_stall2", 32'(stall_req), 32'd0);
    issue_valid = 1'b1; issue_sel = 4'b0001; issue_tag = 5'd8; unit_result[0 +: 32] = 32'h5A;
    step();
    issue_valid = 1'b0; unit_result = '0;
    #1;
    chk("c_idle_valid", 32'(out_valid), 32'd1);
    chk("c_idle_data",  out_data,       32'h5A);

    // back-to-back single-cycle issues
    issue_valid = 1'b1; issue_sel = 4'b0001; issue_tag = 5'd1; unit_result = '0;
    unit_result[0 +: 32] = 32'h11;
    step();
    issue_sel = 4'b1000; issue_tag = 5'd2; unit_result = '0; unit_result[96 +: 32] = 32'hFF;
    #1;
    chk("d_valid1", 32'(out_valid), 32'd1);
    chk("d_data1",  out_data,       32'h11);
    chk("d_tag1",   32'(out_tag),   32'd1);
    step();
    issue_valid = 1'b0; unit_result = '0;
    #1;
    chk("d_valid2", 32'(out_valid), 32'd1);
    chk("d_data2",  out_data,       32'hFF);
    chk("d_tag2",   32'(out_tag),   32'd2);
    step();
    chk("d_valid_drop", 32'(out_valid), 32'd0);

    // reset asserted mid-WAIT
    issue_valid = 1'b1; issue_sel = 4'b0010; issue_tag = 5'd5;
    step();
    issue_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("e_valid", 32'(out_valid), 32'd0);
    chk("e_data",  out_data,       32'd0);
    chk("e_tag",   32'(out_tag),   32'd0);
    chk("e_err",   32'(sel_error), 32'd0);
    chk("e_stall", 32'(stall_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_result_collect.md
Name: ex_result_collect

Overview:
- Next-generation EX-stage result selector.
- Gathers results from NUM_UNITS functional units (adder, multiplier, divider, logic, ...) under a one-hot select.
- Single-cycle units return a registered result one cycle after issue. For multi-cycle units, the block raises a stall request, waits for the unit's done pulse, then returns its result.
- Sits between the functional units and the EX/MEM pipeline register; drives the stall request to the hazard unit.

Parameters:
- DATA_WIDTH, 32, result width.
- NUM_UNITS, 4, number of functional units (select width).
- TAG_WIDTH, 5, destination-register tag width.
- MULTI_MASK, 4'b0110, bit k=1 marks unit k as multi-cycle (default: unit1 multiplier, unit2 divider).
- TIMEOUT, 64, maximum cycles to wait for unit_done before abort (must be at least 2).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous pipeline flush
- issue_valid  in  1  operation issued this cycle
- issue_sel  in  NUM_UNITS  one-hot unit select
- issue_tag  in  TAG_WIDTH  destination tag of issued op
- unit_result  in  NUM_UNITS*DATA_WIDTH  packed unit results, unit k at [k*DATA_WIDTH +: DATA_WIDTH]
- unit_done  in  NUM_UNITS  per-unit completion pulse (multi-cycle units only)
- out_valid  out  1  one-cycle pulse, result available
- out_data  out  DATA_WIDTH  selected result
- out_tag  out  TAG_WIDTH  tag of result
- stall_req  out  1  hold issue stage
- sel_error  out  1  one-cycle pulse: illegal select or timeout

Behaviour:
- Only clk and rst are fixed; rst is synchronous active-high, flush is also synchronous; rst has priority over flush, flush over everything else.
- Reset values: state IDLE; out_valid=0; out_data=0; out_tag=0; sel_error=0; stall_req=0; wait counter=0.
- States: IDLE, WAIT.
- IDLE, issue_valid=0:
  - out_valid=0 next cycle.
  - out_data and out_tag hold their last values.
- IDLE, issue_valid=1, issue_sel one-hot at bit k, MULTI_MASK[k]=0:
  - Next cycle: out_valid=1, out_data = unit k's slice sampled in the issue cycle, out_tag = issue_tag.
  - Latency 1. Back-to-back issues give back-to-back out_valid.
- IDLE, issue_valid=1, one-hot bit k, MULTI_MASK[k]=1:
  - stall_req=1 combinationally in the issue cycle.
  - Capture k and issue_tag; go to WAIT; clear the counter.
  - unit_done in the issue cycle is ignored.
- IDLE, issue_valid=1, issue_sel zero or more than one bit set:
  - Next cycle: out_valid=1, out_data=0, out_tag=issue_tag, sel_error=1 for one cycle.
  - Stay in IDLE.
- WAIT:
  - stall_req=1 every cycle until the done cycle.
  - issue_valid/issue_sel/issue_tag are ignored (upstream holds while stalled).
  - unit_done on any unit other than the captured one is ignored.
  - The counter increments each WAIT cycle.
- WAIT, unit_done[k]=1 for the captured unit:
  - stall_req=0 combinationally in that cycle.
  - Next cycle: out_valid=1, out_data = unit k's slice sampled in the done cycle, out_tag = captured tag.
  - Return to IDLE. A new issue is accepted from the cycle after done.
- WAIT timeout: counter reaches TIMEOUT-1 without done →
  - Next cycle: sel_error=1, out_valid=0, return to IDLE.
  - stall_req drops in the following cycle.
  - Done coincident with the final count wins (normal completion, no error).
- flush in any state:
  - Next cycle: state IDLE, out_valid=0, sel_error=0, counter cleared.
  - stall_req=0 from the cycle after flush.
  - An issue or done in the flush cycle is dropped.
  - out_data and out_tag retain their values.
- out_valid and sel_error are never high for more than one consecutive cycle, except back-to-back single-cycle issues, where out_valid may stay high.

Test Plan:
- Reset, then issue sel=4'b0001 with unit0=32'h0000_0005, tag=3 → next cycle out_valid=1, out_data=32'h5, out_tag=3, stall_req stays 0.
- Issue sel=4'b0010, tag=7; unit_done[1] 4 cycles later with unit1=32'h0000_00C8 → stall_req=1 for 5 cycles (issue cycle plus 4 WAIT cycles, done cycle low); next cycle out_valid=1, out_data=32'hC8, out_tag=7.
- Issue sel=4'b0101, tag=2 → next cycle out_valid=1, out_data=0, sel_error=1; state stays IDLE.
- Issue sel=4'b0100 with no done for 64 cycles → sel_error pulses once, out_valid stays 0, stall_req returns to 0; a later sel=4'b1000 issue completes normally.
- Issue sel=4'b0100, assert flush 2 cycles later together with unit_done[2] → no out_valid, stall_req=0 from the cycle after flush, state IDLE.
- Back-to-back single-cycle issues on sel 4'b0001 then 4'b1000 (values 32'h11, 32'hFF) → out_valid high for 2 consecutive cycles carrying 32'h11 then 32'hFF; rst asserted mid-WAIT clears all outputs to 0 next cycle.
